parallel_axis_capture: RTL and testbench
========================================

# parallel_axis_capture

Frame-aligned, multi-frame capture buffer for the parallel OSPFB output stream, the parametrised successor to the fixed-depth `parallel_axis_vip`. It sits on the DSP clock after the OSPFB and records whole FFT frames into an internal buffer. Capture can be one-shot or continuous ring, with programmable frame count and frame decimation. A 1-cycle-latency read port lets the bench or the control plane read the buffer back.

## Interface
Parameters:
- `SAMP_PER_CLK`, 2: samples per beat.
- `DTYPE`, `cx_t`: sample type.
- `TUSER`, 16: tuser width, stored alongside data.
- `FRAME_LEN`, 64: samples per frame. Must be a multiple of `SAMP_PER_CLK`.
- `MAX_FRAMES`, 4: buffer capacity in frames. `DEPTH = MAX_FRAMES*FRAME_LEN/SAMP_PER_CLK` beats.

Ports:
- `clk`, in, 1: DSP clock. One clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous active-high reset.
- `s_axis`, `alpaca_data_pkt_axis.SLV`, `SAMP_PER_CLK*$bits(DTYPE)` data, `TUSER` user, tlast, tvalid, tready: input stream.
- `arm`, in, 1: start-capture pulse.
- `stop`, in, 1: ring-mode stop request.
- `mode`, in, 1: 0 = one-shot, 1 = ring. Sampled on arm.
- `num_frames`, in, `$clog2(MAX_FRAMES+1)`: frames per pass. 0 means `MAX_FRAMES`; values above `MAX_FRAMES` are clamped. Sampled on arm.
- `skip`, in, 8: frames discarded between captured frames. Sampled on arm.
- `rd_addr`, in, `$clog2(DEPTH)`: readback beat address.
- `rd_data`, out, `SAMP_PER_CLK*$bits(DTYPE)`: readback data.
- `rd_tuser`, out, `TUSER`: readback tuser.
- `state`, out, `capture_state_t`: current FSM state.
- `full`, out, 1: capture complete (DONE).
- `frames_captured`, out, `$clog2(MAX_FRAMES+1)`: valid frames in buffer.
- `last_frame`, out, `$clog2(MAX_FRAMES)`: index of most recently completed frame (ring readback origin).
- `frame_err`, out, 1: sticky framing error.

## Operation
- `s_axis.tready` is held at 1 at all times. The block never backpressures, because the OSPFB output cannot stall.
- A beat is accepted when `tvalid` is high.
- FSM states:
  - `IDLE`:
    - On `arm` → `ALIGN`.
    - Latches `mode`, `num_frames`, `skip`.
    - Clears `frames_captured`, `frame_err` and the write pointer.
  - `ALIGN`: discard beats until an accepted beat with tlast. Then → `CAPTURE` if `skip==0`, else → `SKIP`.
  - `CAPTURE`:
    - Each accepted beat is written at `wr_ptr` and `wr_ptr` increments. The beat counter `bcnt` runs 0 … `FRAME_LEN/SAMP_PER_CLK-1`.
    - A frame completes when tlast arrives on the final beat. On completion, `frames_captured` saturates at `num_frames` and `last_frame` is updated.
    - Next state: `SKIP` if `skip>0`; `DONE` when one-shot and count reached, or when a stop is pending; otherwise stay in `CAPTURE`.
  - `SKIP`: count `skip` complete frames, without writing, → `CAPTURE`.
  - `DONE`: hold the buffer. `arm` re-arms as from `IDLE`.
- Ring mode:
  - `wr_ptr` wraps to 0 after frame `num_frames-1`. Capture continues, overwriting the oldest frame.
  - `stop` is latched as pending. The current frame finishes, then the FSM enters `DONE`.
  - `stop` in `ALIGN` or `SKIP` → `DONE` immediately.
- Framing error:
  - Triggers: tlast before the final beat, or no tlast on the final beat.
  - Response: set `frame_err`, rewind `wr_ptr` to the frame start, do not count the frame, go to `ALIGN`.
  - Exception: a missing tlast goes to `ALIGN`. An early tlast is itself the alignment, so the next state is `CAPTURE` or `SKIP` directly.
- Ignored inputs: `arm` in `ALIGN`, `CAPTURE` or `SKIP`; `stop` in one-shot mode or in `IDLE`.

## Timing
- Reset values:
  - `state`=`IDLE`.
  - `full`, `frame_err`, `frames_captured`, `last_frame` = 0.
  - `rd_data`, `rd_tuser` = 0.
  - The buffer contents are not reset.
- Write: an accepted beat is written in the same cycle.
- `full` rises in the cycle after the final beat of the terminating frame is written.
- `frames_captured` and `last_frame` update in that same cycle.
- Read: `rd_data` and `rd_tuser` are registered, valid one cycle after `rd_addr`.
- Simultaneous read and write to the same address returns the old data.
- `rst` mid-capture aborts in the next cycle and drives all outputs to reset values.
- `arm` and `stop` are single-cycle, level-sampled in the cycle they are high.

## Structure
- `alpaca_dtypes_pkg` gains `typedef enum logic [2:0] {IDLE, ALIGN, CAPTURE, SKIP, DONE} capture_state_t`.
- Width constants are local `localparam`s.
- One sub-module, `capture_sdp_ram`: simple dual-port, one write port and one registered read port, width `SAMP_PER_CLK*$bits(DTYPE)+TUSER`, depth `DEPTH`, read-first.

## Test plan
- One-shot, `num_frames`=2, `skip`=0, arm mid-frame → first partial frame discarded; beats 0–63 hold the next two frames in order; `full` rises 1 cycle after beat 63; `frames_captured`=2.
- `skip`=1, `num_frames`=3 → buffer holds stream frames k, k+2, k+4; intervening frames absent.
- Ring, `num_frames`=4, run 6 frames then `stop` mid-frame 7 → that frame completes; `last_frame`=2 (frame 7 landed in slot 2); slots hold frames 4,5,6,7 cyclically; `frames_captured`=4.
- tlast injected at beat 10 of a 32-beat frame → `frame_err`=1; partial frame not counted; next complete frame written at the same base address.
- Continuous tvalid with readback → `rd_data` matches the written beat exactly one cycle after `rd_addr`; `tready` never deasserts.
- `rst` asserted during `CAPTURE` → next cycle `state`=`IDLE`, `full`=0, `frames_captured`=0; re-arm captures correctly.

Source files
------------

// File: rtl/parallel_axis_capture_pkg.sv
// Shared types for the parallel OSPFB capture buffer.
// Sample type and capture FSM state encoding.
package parallel_axis_capture_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cx_t;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        CAPTURE,
        SKIP,
        DONE
    } capture_state_t;

endpackage

// File: rtl/parallel_axis_capture_if.sv
// AXI-stream bundle for the parallel OSPFB data path.
// Carries data, tuser, tlast and the valid/ready handshake.
interface alpaca_data_pkt_axis #(
    parameter int DATA_W = 64,
    parameter int USER_W = 16
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport MST (
        output tdata, tuser, tlast, tvalid,
        input  tready
    );

    modport SLV (
        input  tdata, tuser, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/parallel_axis_capture_sdp_ram.sv
// Simple dual-port buffer: one write port, one registered read port.
// Read-first: a same-address read and write returns the old word.
module capture_sdp_ram #(
    parameter int W     = 80,
    parameter int DEPTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rd
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd <= '0;
        else
            rd <= mem[ra];
    end
endmodule

// File: rtl/parallel_axis_capture.sv
// Frame-aligned multi-frame capture of the parallel OSPFB stream,
// one-shot or ring, with frame decimation and 1-cycle readback.
module parallel_axis_capture
    import parallel_axis_capture_pkg::*;
#(
    parameter int  SAMP_PER_CLK = 2,
    parameter type DTYPE        = cx_t,
    parameter int  TUSER        = 16,
    parameter int  FRAME_LEN    = 64,
    parameter int  MAX_FRAMES   = 4,
    localparam int DW    = SAMP_PER_CLK * $bits(DTYPE),
    localparam int BPF   = FRAME_LEN / SAMP_PER_CLK,
    localparam int DEPTH = MAX_FRAMES * BPF,
    localparam int AW    = $clog2(DEPTH),
    localparam int FCW   = $clog2(MAX_FRAMES + 1),
    localparam int LFW   = $clog2(MAX_FRAMES)
) (
    input  logic            clk,
    input  logic            rst,
    alpaca_data_pkt_axis.SLV s_axis,
    input  logic            arm,
    input  logic            stop,
    input  logic            mode,
    input  logic [FCW-1:0]  num_frames,
    input  logic [7:0]      skip,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data,
    output logic [TUSER-1:0] rd_tuser,
    output capture_state_t  state,
    output logic            full,
    output logic [FCW-1:0]  frames_captured,
    output logic [LFW-1:0]  last_frame,
    output logic            frame_err
);
    localparam int BW = (BPF > 1) ? $clog2(BPF) : 1;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BPF - 1);
    localparam logic [FCW-1:0] MAXF      = FCW'(MAX_FRAMES);

    logic           m_mode;
    logic [FCW-1:0] m_num;
    logic [7:0]     m_skip;
    logic [7:0]     skcnt;
    logic           stop_pend;
    logic [BW-1:0]  bcnt;
    logic [AW-1:0]  fbase;
    logic [LFW-1:0] fidx;

    logic           beat, eof, last_beat;
    logic           go_arm, stop_now, we;
    logic [AW-1:0]  wa;
    logic [FCW-1:0] fc_next;
    logic [DW+TUSER-1:0] rq;

    assign s_axis.tready = 1'b1;
    assign beat      = s_axis.tvalid;
    assign eof       = beat & s_axis.tlast;
    assign last_beat = (bcnt == LAST_BEAT);
    assign go_arm    = arm & ((state == IDLE) | (state == DONE));
    assign stop_now  = m_mode & (stop | stop_pend);
    assign full      = (state == DONE);
    assign we        = (state == CAPTURE) & beat;
    // Write pointer is frame base plus beat index, so a rewind is just bcnt=0.
    assign wa        = fbase + AW'(bcnt);
    assign fc_next   = (frames_captured >= m_num) ? m_num
                                                  : frames_captured + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            frames_captured <= '0;
            last_frame      <= '0;
            frame_err       <= 1'b0;
            m_mode          <= 1'b0;
            m_num           <= MAXF;
            m_skip          <= '0;
            skcnt           <= '0;
            stop_pend       <= 1'b0;
            bcnt            <= '0;
            fbase           <= '0;
            fidx            <= '0;
        end else if (go_arm) begin
            state           <= ALIGN;
            m_mode          <= mode;
            m_num           <= (num_frames == '0 || num_frames > MAXF)
                               ? MAXF : num_frames;
            m_skip          <= skip;
            frames_captured <= '0;
            frame_err       <= 1'b0;
            stop_pend       <= 1'b0;
            bcnt            <= '0;
            fbase           <= '0;
            fidx            <= '0;
        end else begin
            unique case (state)
                ALIGN: begin
                    if (stop_now) begin
                        state <= DONE;
                    end else if (eof) begin
                        state <= (m_skip == '0) ? CAPTURE : SKIP;
                        skcnt <= m_skip;
                    end
                end
                SKIP: begin
                    if (stop_now) begin
                        state <= DONE;
                    end else if (eof) begin
                        if (skcnt <= 8'd1)
                            state <= CAPTURE;
                        skcnt <= skcnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    if (m_mode & stop)
                        stop_pend <= 1'b1;
                    if (beat) begin
                        if (eof && last_beat) begin
                            bcnt            <= '0;
                            frames_captured <= fc_next;
                            last_frame      <= fidx;
                            skcnt           <= m_skip;
                            if (FCW'(fidx) == m_num - 1'b1) begin
                                fidx  <= '0;
                                fbase <= '0;
                            end else begin
                                fidx  <= fidx + 1'b1;
                                fbase <= fbase + AW'(BPF);
                            end
                            if ((!m_mode && fc_next == m_num) || stop_now)
                                state <= DONE;
                            else if (m_skip != '0)
                                state <= SKIP;
                        end else if (s_axis.tlast || last_beat) begin
                            // Early tlast already re-aligns; missing tlast does not.
                            frame_err <= 1'b1;
                            bcnt      <= '0;
                            skcnt     <= m_skip;
                            if (stop_now)
                                state <= DONE;
                            else if (!s_axis.tlast)
                                state <= ALIGN;
                            else if (m_skip != '0)
                                state <= SKIP;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    capture_sdp_ram #(
        .W     (DW + TUSER),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .wa  (wa),
        .wd  ({s_axis.tuser, s_axis.tdata}),
        .ra  (rd_addr),
        .rd  (rq)
    );

    assign {rd_tuser, rd_data} = rq;
endmodule

// File: tb/tb_parallel_axis_capture.sv
// Directed bench for parallel_axis_capture: alignment, decimation,
// ring wrap/stop, framing error, readback timing and mid-capture reset.
module tb_parallel_axis_capture;
    import parallel_axis_capture_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alpaca_data_pkt_axis #(.DATA_W(64), .USER_W(16)) s_axis ();

    logic           arm, stop, mode;
    logic [2:0]     num_frames;
    logic [7:0]     skip;
    logic [6:0]     rd_addr;
    logic [63:0]    rd_data;
    logic [15:0]    rd_tuser;
    capture_state_t state;
    logic           full;
    logic [2:0]     frames_captured;
    logic [1:0]     last_frame;
    logic           frame_err;

    parallel_axis_capture dut (
        .clk             (clk),
        .rst             (rst),
        .s_axis          (s_axis),
        .arm             (arm),
        .stop            (stop),
        .mode            (mode),
        .num_frames      (num_frames),
        .skip            (skip),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .rd_tuser        (rd_tuser),
        .state           (state),
        .full            (full),
        .frames_captured (frames_captured),
        .last_frame      (last_frame),
        .frame_err       (frame_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [79:0] got,
                         input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] pat(input int f, input int b);
        return {8'(f), 8'(b), 32'(f), 32'(b)};
    endfunction

    task automatic beat(input int f, input int b, input bit last,
                        input bit a = 1'b0, input bit s = 1'b0);
        @(negedge clk);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = {32'(f), 32'(b)};
        s_axis.tuser  = {8'(f), 8'(b)};
        s_axis.tlast  = last;
        arm  = a;
        stop = s;
    endtask

    task automatic idle();
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        arm  = 1'b0;
        stop = 1'b0;
    endtask

    task automatic frame(input int f);
        for (int b = 0; b < 32; b++)
            beat(f, b, b == 31);
    endtask

    task automatic rd_chk(input string tag, input int addr,
                          input int f, input int b);
        @(negedge clk);
        rd_addr = 7'(addr);
        @(negedge clk);
        check(tag, {rd_tuser, rd_data}, pat(f, b));
    endtask

    initial begin
        rst = 1'b1;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tuser  = '0;
        arm = 1'b0; stop = 1'b0; mode = 1'b0;
        num_frames = 3'd0; skip = 8'd0; rd_addr = 7'd0;
        repeat (3) @(negedge clk);
        check("rst_state", 80'(state), 80'(IDLE));
        check("rst_full", 80'(full), 80'd0);
        check("rst_fc", 80'(frames_captured), 80'd0);
        check("rst_lf", 80'(last_frame), 80'd0);
        check("rst_err", 80'(frame_err), 80'd0);
        check("rst_rd", {rd_tuser, rd_data}, 80'd0);
        check("tready", 80'(s_axis.tready), 80'd1);
        rst = 1'b0;

        // one-shot, 2 frames, armed mid-frame
        mode = 1'b0; num_frames = 3'd2; skip = 8'd0;
        for (int b = 0; b < 32; b++)
            beat(0, b, b == 31, b == 5);
        frame(1);
        for (int b = 0; b < 31; b++)
            beat(2, b, 1'b0);
        beat(2, 31, 1'b1);
        check("os_full_pre", 80'(full), 80'd0);
        idle();
        check("os_full", 80'(full), 80'd1);
        check("os_state", 80'(state), 80'(DONE));
        check("os_fc", 80'(frames_captured), 80'd2);
        check("os_lf", 80'(last_frame), 80'd1);
        check("os_err", 80'(frame_err), 80'd0);
        frame(3);
        idle();
        rd_chk("os_a0", 0, 1, 0);
        rd_chk("os_a31", 31, 1, 31);
        rd_chk("os_a32", 32, 2, 0);
        rd_chk("os_a63", 63, 2, 31);

        // one-shot, decimate by 2
        mode = 1'b0; num_frames = 3'd3; skip = 8'd1;
        beat(10, 0, 1'b0, 1'b1);
        for (int b = 1; b < 32; b++)
            beat(10, b, b == 31);
        for (int f = 11; f < 16; f++)
            frame(f);
        for (int b = 0; b < 31; b++)
            beat(16, b, 1'b0);
        beat(16, 31, 1'b1);
        check("sk_full_pre", 80'(full), 80'd0);
        idle();
        check("sk_full", 80'(full), 80'd1);
        check("sk_fc", 80'(frames_captured), 80'd3);
        check("sk_lf", 80'(last_frame), 80'd2);
        rd_chk("sk_a0", 0, 12, 0);
        rd_chk("sk_a32", 32, 14, 0);
        rd_chk("sk_a64", 64, 16, 0);
        rd_chk("sk_a95", 95, 16, 31);

        // ring of 4, stop mid 7th frame
        mode = 1'b1; num_frames = 3'd4; skip = 8'd0;
        beat(20, 0, 1'b0, 1'b1);
        for (int b = 1; b < 32; b++)
            beat(20, b, b == 31);
        for (int f = 21; f < 27; f++)
            frame(f);
        for (int b = 0; b < 10; b++)
            beat(27, b, 1'b0);
        beat(27, 10, 1'b0, 1'b0, 1'b1);
        for (int b = 11; b < 31; b++)
            beat(27, b, 1'b0);
        check("rg_state_pend", 80'(state), 80'(CAPTURE));
        beat(27, 31, 1'b1);
        check("rg_full_pre", 80'(full), 80'd0);
        idle();
        check("rg_full", 80'(full), 80'd1);
        check("rg_fc", 80'(frames_captured), 80'd4);
        check("rg_lf", 80'(last_frame), 80'd2);
        rd_chk("rg_a0", 0, 25, 0);
        rd_chk("rg_a32", 32, 26, 0);
        rd_chk("rg_a64", 64, 27, 0);
        rd_chk("rg_a96", 96, 24, 0);
        rd_chk("rg_a127", 127, 24, 31);

        // early tlast, plus same-address read during write
        mode = 1'b0; num_frames = 3'd2; skip = 8'd0;
        beat(30, 0, 1'b0, 1'b1);
        for (int b = 1; b < 32; b++)
            beat(30, b, b == 31);
        for (int b = 0; b < 10; b++)
            beat(31, b, 1'b0);
        beat(31, 10, 1'b1);
        rd_addr = 7'd0;
        beat(32, 0, 1'b0);
        check("fe_err", 80'(frame_err), 80'd1);
        check("fe_state", 80'(state), 80'(CAPTURE));
        check("fe_fc", 80'(frames_captured), 80'd0);
        beat(32, 1, 1'b0);
        check("rdw_old", {rd_tuser, rd_data}, pat(31, 0));
        beat(32, 2, 1'b0);
        check("rdw_new", {rd_tuser, rd_data}, pat(32, 0));
        for (int b = 3; b < 32; b++)
            beat(32, b, b == 31);
        for (int b = 0; b < 31; b++)
            beat(33, b, 1'b0);
        beat(33, 31, 1'b1);
        idle();
        check("fe_full", 80'(full), 80'd1);
        check("fe_fc2", 80'(frames_captured), 80'd2);
        check("fe_err_sticky", 80'(frame_err), 80'd1);
        rd_chk("fe_a10", 10, 32, 10);
        rd_chk("fe_a31", 31, 32, 31);
        rd_chk("fe_a32", 32, 33, 0);

        // readback under continuous tvalid
        for (int i = 0; i < 8; i++) begin
            beat(34, i, 1'b0);
            if (i > 0)
                check("rb_stream", {rd_tuser, rd_data}, pat(32, i - 1));
            check("rb_tready", 80'(s_axis.tready), 80'd1);
            rd_addr = 7'(i);
        end

        // reset mid-capture, then re-arm
        mode = 1'b0; num_frames = 3'd1; skip = 8'd0;
        beat(40, 0, 1'b0, 1'b1);
        for (int b = 1; b < 32; b++)
            beat(40, b, b == 31);
        for (int b = 0; b < 10; b++)
            beat(41, b, 1'b0);
        check("rs_pre_state", 80'(state), 80'(CAPTURE));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rs_state", 80'(state), 80'(IDLE));
        check("rs_full", 80'(full), 80'd0);
        check("rs_fc", 80'(frames_captured), 80'd0);
        check("rs_rd", {rd_tuser, rd_data}, 80'd0);
        beat(42, 0, 1'b0, 1'b1);
        for (int b = 1; b < 32; b++)
            beat(42, b, b == 31);
        for (int b = 0; b < 31; b++)
            beat(43, b, 1'b0);
        beat(43, 31, 1'b1);
        idle();
        check("ra_full", 80'(full), 80'd1);
        check("ra_fc", 80'(frames_captured), 80'd1);
        check("ra_lf", 80'(last_frame), 80'd0);
        rd_chk("ra_a0", 0, 43, 0);
        rd_chk("ra_a31", 31, 43, 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
